// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
// Module  : data_cache_if
// Purpose : M-stage pipeline side and backing-memory side signals of the cache
// Revision: 1.0  initial release
// ============================================================================
interface data_cache_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  MemReadM;
    logic                  MemWriteM;
    logic [DATA_WIDTH-1:0] ALUResultM;
    logic [DATA_WIDTH-1:0] WriteDataM;
    logic [DATA_WIDTH-1:0] ReadDataM;
    logic                  StallM;

    logic                  MemReq;
    logic                  MemWe;
    logic [DATA_WIDTH-1:0] MemAddr;
    logic [DATA_WIDTH-1:0] MemWData;
    logic                  MemReady;
    logic                  MemRValid;
    logic [DATA_WIDTH-1:0] MemRData;

    // master: the pipeline plus the backing memory; slave: the cache
    modport master (
        output MemReadM, MemWriteM, ALUResultM, WriteDataM,
        output MemReady, MemRValid, MemRData,
        input  ReadDataM, StallM, MemReq, MemWe, MemAddr, MemWData
    );

    modport slave (
        input  MemReadM, MemWriteM, ALUResultM, WriteDataM,
        input  MemReady, MemRValid, MemRData,
        output ReadDataM, StallM, MemReq, MemWe, MemAddr, MemWData
    );
endinterface
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module  : data_cache
// Purpose : Direct-mapped, write-through, no-write-allocate M-stage data cache
// Revision: 1.0  initial release
// ============================================================================
module data_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    data_cache_if.slave  bus
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] C_LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WRITE       = 3'd1,
        REFILL_REQ  = 3'd2,
        REFILL_WAIT = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [OFF_W-1:0]        r_cnt;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [DATA_WIDTH-1:0]   r_data [LINES*WORDS_PER_LINE];

    logic [TAG_W-1:0]        w_tag;
    logic [IDX_W-1:0]        w_idx;
    logic [OFF_W-1:0]        w_off;
    logic                    w_hit;
    logic                    w_is_wr;
    logic                    w_is_rd;
    logic [DATA_WIDTH-1:0]   w_line_word;
    logic                    w_unused_addr_lo;

    logic                    w_stall;
    logic                    w_req;
    logic                    w_we;
    logic [DATA_WIDTH-1:0]   w_maddr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_clr_valid;
    logic                    w_set_line;
    logic                    w_fill;
    logic                    w_wr_hit;
    logic                    w_cnt_clr;
    logic                    w_cnt_inc;

    assign w_tag            = bus.ALUResultM[DATA_WIDTH-1 -: TAG_W];
    assign w_idx            = bus.ALUResultM[2+OFF_W +: IDX_W];
    assign w_off            = bus.ALUResultM[2 +: OFF_W];
    assign w_unused_addr_lo = ^bus.ALUResultM[1:0];

    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_is_wr     = bus.MemWriteM;
    assign w_is_rd     = bus.MemReadM & ~bus.MemWriteM;
    assign w_line_word = r_data[{w_idx, w_off}];

    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_maddr     = '0;
        w_wdata     = '0;
        w_rdata     = '0;
        w_clr_valid = 1'b0;
        w_set_line  = 1'b0;
        w_fill      = 1'b0;
        w_wr_hit    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_is_wr) begin
                    w_stall = 1'b1;
                    w_next  = WRITE;
                end else if (w_is_rd) begin
                    if (w_hit) begin
                        w_rdata = w_line_word;
                    end else begin
                        // Line is invalidated up front so a refill cut short by reset never hits
                        w_stall     = 1'b1;
                        w_clr_valid = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_next      = REFILL_REQ;
                    end
                end
            end
            WRITE: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_maddr = {bus.ALUResultM[DATA_WIDTH-1:2], 2'b00};
                w_wdata = bus.WriteDataM;
                if (bus.MemReady) begin
                    w_wr_hit = w_hit;
                    w_next   = DONE;
                end
            end
            REFILL_REQ: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                w_maddr = {w_tag, w_idx, r_cnt, 2'b00};
                if (bus.MemReady) begin
                    w_next = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                w_stall = 1'b1;
                if (bus.MemRValid) begin
                    w_fill = 1'b1;
                    if (r_cnt == C_LAST_WORD) begin
                        w_set_line = 1'b1;
                        w_next     = DONE;
                    end else begin
                        w_cnt_inc = 1'b1;
                        w_next    = REFILL_REQ;
                    end
                end
            end
            DONE: begin
                if (w_is_rd) begin
                    w_rdata = w_line_word;
                end
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_clr_valid) begin
            r_valid[w_idx] <= 1'b0;
        end else if (w_set_line) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_set_line) begin
            r_tag[w_idx] <= w_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[{w_idx, r_cnt}] <= bus.MemRData;
        end else if (w_wr_hit) begin
            r_data[{w_idx, w_off}] <= bus.WriteDataM;
        end
    end

    // Stall is masked while reset is held so a pending request does not freeze the pipe
    assign bus.StallM    = w_stall & ~reset;
    assign bus.MemReq    = w_req;
    assign bus.MemWe     = w_we;
    assign bus.MemAddr   = w_maddr;
    assign bus.MemWData  = w_wdata;
    assign bus.ReadDataM = w_rdata;

endmodule
`default_nettype wire

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache for the memory-access stage of the 5-stage pipelined core. It sits between the execute–memory pipeline register and the backing data memory. It returns ReadDataM to the memory–writeback pipeline register, and asserts StallM to the hazard unit while a refill or write-through is in progress. The backing memory is reached through a single-word valid/ready request channel with a separate read-response strobe.

## Interface
- DATA_WIDTH, 32, word and address width
- LINES, 16, number of cache lines (power of two)
- WORDS_PER_LINE, 4, words per line (power of two)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- ALUResultM  in  DATA_WIDTH  byte address; bits [1:0] ignored (word accesses only)
- WriteDataM  in  DATA_WIDTH  store data
- ReadDataM  out  DATA_WIDTH  load data
- StallM  out  1  pipeline must hold F/D/E/M; the request stays stable while high
- MemReq  out  1  backing-memory request valid
- MemWe  out  1  request is a write
- MemAddr  out  DATA_WIDTH  word-aligned byte address
- MemWData  out  DATA_WIDTH  write data
- MemReady  in  1  request accepted this cycle (MemReq & MemReady)
- MemRValid  in  1  read response valid; earliest one cycle after acceptance
- MemRData  in  DATA_WIDTH  read response data

## Operation
- Address split with defaults: offset = addr[3:2], index = addr[7:4], tag = addr[31:8]. Widths derive from $clog2 of the parameters.
- Storage:
  - Valid bit per line, cleared by reset.
  - Tag array per line, not reset.
  - Data array of LINES×WORDS_PER_LINE words, not reset.
- Hit = valid[index] and tag[index] == tag.
- MemReadM and MemWriteM both high: treat as a write.
- FSM states: IDLE, WRITE, REFILL_REQ, REFILL_WAIT, DONE.
- IDLE behaviour:
  - Read hit: ReadDataM = data[index][offset] combinationally; StallM = 0.
  - Read miss: StallM = 1. Clear valid[index]. Set counter = 0. Next state is REFILL_REQ.
  - Write: StallM = 1. Next state is WRITE.
  - No request: StallM = 0, MemReq = 0.
- WRITE:
  - MemReq = 1, MemWe = 1, MemAddr = {addr[31:2], 2'b00}, MemWData = WriteDataM.
  - Held until MemReady. On acceptance, if hit, write WriteDataM into data[index][offset]. A miss allocates nothing.
  - Next state is DONE.
- REFILL_REQ:
  - MemReq = 1, MemWe = 0, MemAddr = {tag, index, counter, 2'b00}.
  - On MemReady, next state is REFILL_WAIT.
- REFILL_WAIT:
  - MemReq = 0. On MemRValid, write MemRData into data[index][counter].
  - If counter == WORDS_PER_LINE-1: set tag[index] and valid[index], next state is DONE.
  - Otherwise counter++ and next state is REFILL_REQ.
- DONE:
  - StallM = 0 for exactly one cycle. For a read, ReadDataM = data[index][offset] (now a hit).
  - The request present in DONE is the completed one and is not reprocessed. Next state is IDLE.
- At most one outstanding memory transaction. MemRValid outside REFILL_WAIT is ignored.
- StallM in WRITE, REFILL_REQ and REFILL_WAIT is 1.

## Timing
- Reset (asynchronous, while reset is high):
  - state = IDLE, counter = 0, all valid bits = 0.
  - StallM = 0, MemReq = 0, MemWe = 0; MemAddr, MemWData and ReadDataM read 0.
- Reset mid-refill or mid-write: MemReq drops in the same cycle as reset. The partially filled line stays invalid. A late MemRValid is ignored.
- Read hit: zero added latency; data valid in the same cycle as MemReadM.
- Read miss with MemReady always 1 and MemRValid one cycle after acceptance: StallM is high for 1 + 2×WORDS_PER_LINE = 9 cycles, then DONE.
- Write with MemReady always 1: StallM is high for 2 cycles (IDLE, WRITE), then DONE.
- Each cycle of MemReady = 0 extends WRITE or REFILL_REQ by one cycle. MemAddr, MemWe and MemWData stay stable while MemReq & !MemReady.
- The counter wraps only through the FSM. WORDS_PER_LINE responses always complete a line.

## Test plan
- Cold read miss: reset, then read 0x0000_0100 with memory returning 0xA0+i for word i. Required response:
  - MemAddr sequence is 0x100, 0x104, 0x108, 0x10C.
  - StallM is high for 9 cycles.
  - ReadDataM = 0xA0 in DONE.
  - A following read of 0x108 hits with no stall and returns 0xA2.
- Write hit: after the fill above, write 0xDEADBEEF to 0x104. Required response:
  - One memory write at 0x104.
  - StallM is high for 2 cycles.
  - A subsequent read of 0x104 hits and returns 0xDEADBEEF.
- Write miss: write 0x55 to 0x0000_0200 (index 0, different tag). Required response:
  - A memory write occurs.
  - The line at index 0 still hits for 0x100.
  - A read of 0x200 then misses.
- Conflict eviction: read 0x100, then read 0x200. Required response:
  - The second read refills index 0.
  - A read of 0x100 then misses again.
- Backpressure: hold MemReady = 0 for 3 cycles on each refill request. Required response:
  - StallM is high for 9 + 12 = 21 cycles.
  - MemAddr is stable during each hold.
- Reset mid-refill: assert reset after the second MemRValid. Required response:
  - MemReq = 0 immediately.
  - A subsequent read of the same address performs a full 4-word refill.
